// File: rtl/drive_pulse_sequencer.sv
// drive_pulse_sequencer
// Multi-channel, trigger-driven pulse sequencer. Each channel owns an
// instruction queue, a small IDLE/LOAD/PLAY/WAIT engine and an NCO phase
// accumulator with a virtual-Z offset. It drives the envelope-memory read
// ports and the sin/cos LUT phase inputs of the drive datapath.
// Optional feature macro: DRIVE_SEQ_PHASE_RESET_EN. When defined, a trigger
// accepted in IDLE zeroes the channel's phase accumulator and Z offset so
// every shot starts from phase 0.
module drive_pulse_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int QUEUE_DEPTH = 8,
    parameter int ENVE_AW     = 8,
    parameter int NCO_N       = 22,
    parameter int INST_W      = 2 + 2 * ENVE_AW + NCO_N
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        trigger,
    input  logic [NUM_CH-1:0]           inst_wr_en,
    input  logic [INST_W-1:0]           inst_wr_data,
    output logic [NUM_CH-1:0]           inst_wr_ready,
    input  logic [NUM_CH-1:0]           ftw_wr_en,
    input  logic [NCO_N-1:0]            ftw_in,
    output logic [NUM_CH-1:0]           env_valid,
    output logic [NUM_CH*ENVE_AW-1:0]   env_addr,
    output logic [NUM_CH*NCO_N-1:0]     phase_out,
    output logic [NUM_CH-1:0]           busy,
    output logic [NUM_CH-1:0]           done,
    output logic [NUM_CH-1:0]           err_ovf
);

    localparam int PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int LEN_LSB   = NCO_N;
    localparam int START_LSB = NCO_N + ENVE_AW;
    localparam int OP_LSB    = NCO_N + 2 * ENVE_AW;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_WAIT} state_e;
    typedef enum logic [1:0] {OP_NOP, OP_PLAY, OP_VZ, OP_WAIT} op_e;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [INST_W-1:0]  mem_q [QUEUE_DEPTH];
        logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
        logic [CNT_W-1:0]   count_q;
        logic               full, empty, push, pop;
        state_e             state_q, state_d;
        logic [ENVE_AW-1:0] cnt_q, cnt_d, addr_q, addr_d;
        logic [NCO_N-1:0]   ftw_q, acc_q, acc_d, zoff_q, zoff_d, phase_q;
        logic               done_q, done_d, ovf_q;
        logic [INST_W-1:0]  head;
        op_e                head_op;
        logic [ENVE_AW-1:0] head_start, head_len;
        logic [NCO_N-1:0]   head_zph;

        assign full       = (count_q == CNT_W'(QUEUE_DEPTH));
        assign empty      = (count_q == '0);
        assign push       = inst_wr_en[c] && !full;
        assign head       = mem_q[rd_ptr_q];
        assign head_op    = op_e'(head[OP_LSB +: 2]);
        assign head_start = head[START_LSB +: ENVE_AW];
        assign head_len   = head[LEN_LSB +: ENVE_AW];
        assign head_zph   = head[NCO_N-1:0];

        // Instruction storage write port.
        // NOTE: storage arrays carry no reset; emptiness is tracked by the reset pointers and count alone.
        always_ff @(posedge clk) begin
            if (push) mem_q[wr_ptr_q] <= inst_wr_data;
        end

        // Queue pointers, occupancy count and sticky overflow flag.
        // NOTE: every clocked process uses non-blocking assignments so all registers update from pre-edge values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                if (push && !pop)      count_q <= count_q + CNT_W'(1);
                else if (pop && !push) count_q <= count_q - CNT_W'(1);
                if (inst_wr_en[c] && full) ovf_q <= 1'b1;
            end
        end

        // Sequencer next state, pops, sweep address/length and NCO phase update.
        // NOTE: each target gets a default before the case so no path leaves it unassigned (no latches).
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            addr_d  = addr_q;
            pop     = 1'b0;
            done_d  = 1'b0;
            acc_d   = acc_q + ftw_q;
            zoff_d  = zoff_q;
`ifdef DRIVE_SEQ_PHASE_RESET_EN
            if (trigger && state_q == S_IDLE) begin
                acc_d  = '0;
                zoff_d = '0;
            end
`endif
            case (state_q)
                S_IDLE: if (trigger) state_d = S_LOAD;
                S_LOAD: begin
                    if (empty) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        pop = 1'b1;
                        case (head_op)
                            OP_PLAY: if (head_len != '0) begin
                                state_d = S_PLAY;
                                cnt_d   = head_len;
                                addr_d  = head_start;
                            end
                            OP_WAIT: if (head_len != '0) begin
                                state_d = S_WAIT;
                                cnt_d   = head_len;
                            end
                            OP_VZ:   zoff_d = zoff_q + head_zph;
                            default: ;
                        endcase
                    end
                end
                S_PLAY: begin
                    addr_d = addr_q + ENVE_AW'(1);
                    cnt_d  = cnt_q - ENVE_AW'(1);
                    if (cnt_q == ENVE_AW'(1)) state_d = S_LOAD;
                end
                S_WAIT: begin
                    cnt_d = cnt_q - ENVE_AW'(1);
                    if (cnt_q == ENVE_AW'(1)) state_d = S_LOAD;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Sequencer, NCO and registered output state.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                addr_q  <= '0;
                ftw_q   <= '0;
                acc_q   <= '0;
                zoff_q  <= '0;
                phase_q <= '0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                addr_q  <= addr_d;
                acc_q   <= acc_d;
                zoff_q  <= zoff_d;
                phase_q <= acc_d + zoff_d;
                done_q  <= done_d;
                if (ftw_wr_en[c]) ftw_q <= ftw_in;
            end
        end

        assign inst_wr_ready[c]              = !full;
        assign env_valid[c]                  = (state_q == S_PLAY);
        assign busy[c]                       = (state_q != S_IDLE);
        assign done[c]                       = done_q;
        assign err_ovf[c]                    = ovf_q;
        assign env_addr[c*ENVE_AW +: ENVE_AW] = addr_q;
        assign phase_out[c*NCO_N +: NCO_N]   = phase_q;
    end

endmodule
